bus_arbiter_4to1: RTL and testbench
===================================

# bus_arbiter_4to1

Round-robin arbiter that shares one 32-bit bus among four requesters (e.g. IF, MEM, DMA, debug). It owns the 2-bit select of the shared 4:1 32-bit data mux and produces a registered one-hot grant. It holds each grant until the owner releases it or a watchdog expires, and inserts one dead cycle between owners.

## Interface
Parameters:
- DATA_WIDTH, 32, width of each requester's data and of the bus output
- MAX_HOLD, 16, maximum consecutive granted cycles before forced release (legal range 2..255)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  4  per-requester request level; bit i = requester i; held high for the whole transaction
- in_00  input  DATA_WIDTH  requester 0 data
- in_01  input  DATA_WIDTH  requester 1 data
- in_10  input  DATA_WIDTH  requester 2 data
- in_11  input  DATA_WIDTH  requester 3 data
- gnt  output  4  registered one-hot grant; all zero when no owner
- sel  output  2  registered mux select = index of current or most recent owner
- out  output  DATA_WIDTH  selected data when bus_valid, else 0
- bus_valid  output  1  high exactly when gnt != 0
- timeout  output  1  one-cycle pulse in the cycle after a watchdog forced release

## Operation
- States: IDLE, GRANT, RELEASE. Encoding is 2-bit: IDLE=0, GRANT=1, RELEASE=2. Code 3 is illegal and recovers to IDLE.
- IDLE or RELEASE: if any eligible req is set, pick the winner, load gnt/sel, clear the hold counter, and go to GRANT. Otherwise go to or stay in IDLE with gnt=0.
- Round-robin: the search starts at (last_owner+1) mod 4 and goes upward with wrap. last_owner updates on every grant.
- GRANT, normal release: if req[owner]==0, go to RELEASE and clear gnt.
- GRANT, watchdog release: if the hold counter == MAX_HOLD-1 while req[owner] is still high:
  - go to RELEASE and clear gnt;
  - pulse timeout;
  - set penalty[owner].
- Penalty: a requester with penalty set is ineligible. Its penalty bit clears on the first cycle its req is sampled low.
- Hold counter: 8 bits, counts cycles in GRANT, saturates, resets on each new grant.
- sel keeps its value in IDLE/RELEASE. out is forced to 0 whenever gnt==0.
- Requests from non-owners never preempt the current owner.

## Timing
- Reset values: gnt=0, sel=0, bus_valid=0, timeout=0, out=0, state=IDLE, last_owner=3 (requester 0 has first priority), penalty=0, hold counter=0.
- Request to grant latency: req sampled high at edge k gives gnt visible after edge k, i.e. 1 cycle from IDLE.
- Release: req[owner] sampled low at edge k:
  - gnt=0 (RELEASE) after edge k;
  - the next grant is earliest after edge k+1.
- Minimum dead time between owners is exactly one cycle.
- Watchdog: a grant lasts at most MAX_HOLD cycles, then RELEASE. timeout is high only during that RELEASE cycle.
- out is combinational from registered sel/gnt and the current in_xx, with no added latency.
- Simultaneous events:
  - Owner drops req in the same cycle the watchdog fires: treated as a normal release, no timeout, no penalty.
  - All four requesting at once: strict rotation 0,1,2,3,0, ...
- Reset mid-grant: gnt drops immediately (asynchronous) and no timeout is generated. After reset deasserts, arbitration restarts from requester 0.

## Structure
- Shared header bus_arb_defs.vh holds:
  - state encodings;
  - requester index constants REQ_IF=0, REQ_MEM=1, REQ_DMA=2, REQ_DBG=3;
  - the default MAX_HOLD.
- One sub-module: rr_pick4 (combinational, 4-bit eligible mask plus 2-bit start index, outputs found flag and 2-bit winner).
- The data path instantiates the existing mux4to1_32bit, with ctr=sel and its output gated by bus_valid.

## Test plan
- Reset then req=4'b0100 at cycle 2 -> gnt=4'b0100 and sel=2 from cycle 3; out=in_10 (drive 32'hA5A5_0002).
- req=4'b1111 held, each owner drops req after 3 granted cycles -> grant order 0,1,2,3,0 with exactly one gnt=0 cycle between owners.
- req[1] held for 20 cycles, MAX_HOLD=16 -> gnt[1] high 16 cycles, then timeout pulse 1 cycle, gnt=0. While req[1] stays high, requester 1 is not regranted even if it is the only requester; it is regranted after a low cycle and a new request.
- Owner 2 drops req in the cycle the hold counter reaches 15 -> normal release, timeout stays 0, penalty[2]=0.
- rst asserted asynchronously mid-grant of requester 3 -> gnt=0, out=0 with no clock edge; after release with req=4'b1001, requester 0 wins first.

Source files
------------

// File: rtl/bus_arbiter_4to1_pkg.sv
// Shared definitions for the 4:1 bus arbiter: FSM encoding, requester indices
// and default parameters.
package bus_arbiter_4to1_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  localparam logic [1:0] REQ_IF  = 2'd0;
  localparam logic [1:0] REQ_MEM = 2'd1;
  localparam logic [1:0] REQ_DMA = 2'd2;
  localparam logic [1:0] REQ_DBG = 2'd3;

  localparam int DEFAULT_MAX_HOLD   = 16;
  localparam int DEFAULT_DATA_WIDTH = 32;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] res;
    case (idx)
      REQ_IF:  res = 4'b0001;
      REQ_MEM: res = 4'b0010;
      REQ_DMA: res = 4'b0100;
      REQ_DBG: res = 4'b1000;
      default: res = 4'b0000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/bus_arbiter_4to1_rr_pick4.sv
// Round-robin picker: first set bit of elig at or above start, wrapping mod 4.
module rr_pick4 (
  input  logic [3:0] elig,
  input  logic [1:0] start,
  output logic       found,
  output logic [1:0] winner
);

  logic [1:0] idx_s;

  // scan from the farthest offset down so the nearest eligible index wins
  always_comb begin
    found  = 1'b0;
    winner = start;
    idx_s  = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx_s  = start + 2'(k);
      found  = found | elig[idx_s];
      winner = elig[idx_s] ? idx_s : winner;
    end
  end

endmodule

// File: rtl/mux4to1_32bit.sv
// Plain 4:1 data multiplexer used on the shared bus data path.
module mux4to1_32bit #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in_00,
  input  logic [WIDTH-1:0] in_01,
  input  logic [WIDTH-1:0] in_10,
  input  logic [WIDTH-1:0] in_11,
  input  logic [1:0]       ctr,
  output logic [WIDTH-1:0] out
);

  // select one of the four inputs
  always_comb begin
    case (ctr)
      2'd0:    out = in_00;
      2'd1:    out = in_01;
      2'd2:    out = in_10;
      2'd3:    out = in_11;
      default: out = {WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/bus_arbiter_4to1.sv
// Round-robin owner of a shared 4:1 bus with registered one-hot grant,
// one dead cycle between owners and a hold watchdog with penalty.
module bus_arbiter_4to1
  import bus_arbiter_4to1_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int MAX_HOLD   = DEFAULT_MAX_HOLD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            req,
  input  logic [DATA_WIDTH-1:0] in_00,
  input  logic [DATA_WIDTH-1:0] in_01,
  input  logic [DATA_WIDTH-1:0] in_10,
  input  logic [DATA_WIDTH-1:0] in_11,
  output logic [3:0]            gnt,
  output logic [1:0]            sel,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  bus_valid,
  output logic                  timeout
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  arb_state_e state_r, state_nxt_s;

  logic [3:0]            gnt_r, gnt_nxt_s;
  logic [1:0]            sel_r, sel_nxt_s;
  logic [1:0]            last_r, last_nxt_s;
  logic [3:0]            pen_r, pen_nxt_s;
  logic [7:0]            hold_r, hold_nxt_s;
  logic                  timeout_r, timeout_nxt_s;
  logic                  valid_r;
  logic [3:0]            elig_s;
  logic [1:0]            start_s;
  logic                  found_s;
  logic [1:0]            winner_s;
  logic                  owner_req_s;
  logic                  wd_fire_s;
  logic [DATA_WIDTH-1:0] mux_s;

  assign elig_s      = req & ~pen_r;
  assign start_s     = last_r + 2'd1;
  assign owner_req_s = req[sel_r];
  assign wd_fire_s   = (hold_r == HOLD_LAST);

  rr_pick4 u_pick (
    .elig   (elig_s),
    .start  (start_s),
    .found  (found_s),
    .winner (winner_s)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; the unused code falls back to IDLE
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE, ST_RELEASE: begin
        state_nxt_s = found_s ? ST_GRANT : ST_IDLE;
      end
      ST_GRANT: begin
        if (!owner_req_s) begin
          state_nxt_s = ST_RELEASE;
        end else if (wd_fire_s) begin
          state_nxt_s = ST_RELEASE;
        end else begin
          state_nxt_s = ST_GRANT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // next values of the registered outputs, owner history and watchdog
  always_comb begin
    gnt_nxt_s     = 4'b0000;
    sel_nxt_s     = sel_r;
    last_nxt_s    = last_r;
    hold_nxt_s    = hold_r;
    timeout_nxt_s = 1'b0;
    pen_nxt_s     = pen_r & req;
    case (state_r)
      ST_IDLE, ST_RELEASE: begin
        if (found_s) begin
          gnt_nxt_s  = onehot4(winner_s);
          sel_nxt_s  = winner_s;
          last_nxt_s = winner_s;
          hold_nxt_s = 8'd0;
        end else begin
          gnt_nxt_s  = 4'b0000;
        end
      end
      ST_GRANT: begin
        // a voluntary drop takes precedence over an expiring watchdog
        if (!owner_req_s) begin
          gnt_nxt_s     = 4'b0000;
        end else if (wd_fire_s) begin
          gnt_nxt_s     = 4'b0000;
          timeout_nxt_s = 1'b1;
          pen_nxt_s     = (pen_r & req) | onehot4(sel_r);
        end else begin
          gnt_nxt_s     = gnt_r;
          hold_nxt_s    = (hold_r == 8'hFF) ? hold_r : hold_r + 8'd1;
        end
      end
      default: gnt_nxt_s = 4'b0000;
    endcase
  end

  // registered outputs and arbitration history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_r     <= 4'b0000;
      sel_r     <= REQ_IF;
      last_r    <= REQ_DBG;
      pen_r     <= 4'b0000;
      hold_r    <= 8'd0;
      timeout_r <= 1'b0;
      valid_r   <= 1'b0;
    end else begin
      gnt_r     <= gnt_nxt_s;
      sel_r     <= sel_nxt_s;
      last_r    <= last_nxt_s;
      pen_r     <= pen_nxt_s;
      hold_r    <= hold_nxt_s;
      timeout_r <= timeout_nxt_s;
      valid_r   <= |gnt_nxt_s;
    end
  end

  mux4to1_32bit #(.WIDTH(DATA_WIDTH)) u_mux (
    .in_00 (in_00),
    .in_01 (in_01),
    .in_10 (in_10),
    .in_11 (in_11),
    .ctr   (sel_r),
    .out   (mux_s)
  );

  assign gnt       = gnt_r;
  assign sel       = sel_r;
  assign bus_valid = valid_r;
  assign timeout   = timeout_r;
  assign out       = valid_r ? mux_s : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_bus_arbiter_4to1.sv
// Directed and randomized bench for bus_arbiter_4to1 against a transaction-level
// reference model (owner, granted-cycle count, penalties, rotation pointer).
module tb_bus_arbiter_4to1;

  localparam int MAXH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_v = 4'b0000;
  logic [31:0] din [4];
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic [31:0] out;
  logic        bus_valid;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  // reference model state
  int         m_owner;
  int         m_cnt;
  int         m_last;
  int         m_sel;
  logic [3:0] m_pen;
  logic       m_to;
  int         grants[$];

  always #5 clk = ~clk;

  bus_arbiter_4to1 #(.DATA_WIDTH(32), .MAX_HOLD(MAXH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req_v),
    .in_00     (din[0]),
    .in_01     (din[1]),
    .in_10     (din[2]),
    .in_11     (din[3]),
    .gnt       (gnt),
    .sel       (sel),
    .out       (out),
    .bus_valid (bus_valid),
    .timeout   (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_cnt   = 0;
    m_last  = 3;
    m_sel   = 0;
    m_pen   = 4'b0000;
    m_to    = 1'b0;
  endtask

  // one clock edge of the arbitration rules, using the sampled request levels
  task automatic model_edge();
    logic [3:0] pen_old;
    bit         done;
    int         idx;
    pen_old = m_pen;
    m_pen   = m_pen & req_v;
    m_to    = 1'b0;
    if (m_owner >= 0) begin
      if (!req_v[m_owner]) begin
        m_owner = -1;
      end else if (m_cnt == MAXH) begin
        m_pen[m_owner] = 1'b1;
        m_to    = 1'b1;
        m_owner = -1;
      end else begin
        m_cnt++;
      end
    end else begin
      done = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        idx = (m_last + k) % 4;
        if (!done && req_v[idx] && !pen_old[idx]) begin
          done    = 1'b1;
          m_owner = idx;
          m_sel   = idx;
          m_last  = idx;
          m_cnt   = 1;
          grants.push_back(idx);
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [3:0]  eg;
    logic [31:0] eo;
    eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    eo = (m_owner >= 0) ? din[m_owner] : 32'd0;
    chk({tag, "_gnt"},     32'(gnt),       32'(eg));
    chk({tag, "_sel"},     32'(sel),       32'(m_sel));
    chk({tag, "_valid"},   32'(bus_valid), 32'(m_owner >= 0));
    chk({tag, "_timeout"}, 32'(timeout),   32'(m_to));
    chk({tag, "_out"},     out,            eo);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    req_v = 4'b0000;
    rst   = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic rand_data();
    for (int i = 0; i < 4; i++) din[i] = $urandom;
  endtask

  initial begin : main
    int  n_gnt1;
    int  n_to;
    bit  dropped;

    for (int i = 0; i < 4; i++) din[i] = 32'h1000_0000 + 32'(i);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rst = 1'b0;

    // single requester 2 with a known data pattern
    din[2] = 32'hA5A5_0002;
    req_v  = 4'b0100;
    step("tp1");
    chk("tp1_gnt_direct", 32'(gnt), 32'h4);
    chk("tp1_out_direct", out, 32'hA5A5_0002);
    step("tp1b");

    // everyone requesting, each owner holds three cycles
    do_reset();
    grants.delete();
    for (int c = 0; c < 30; c++) begin
      req_v = 4'b1111;
      if (m_owner >= 0 && m_cnt == 3) req_v[m_owner] = 1'b0;
      step("rot");
      rand_data();
    end
    chk("rot_count", 32'(grants.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++) chk("rot_order", 32'(grants[i]), 32'(i % 4));

    // requester 1 exceeds the hold limit
    do_reset();
    n_gnt1 = 0;
    n_to   = 0;
    req_v  = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      step("wd");
      if (gnt[1]) n_gnt1++;
      if (timeout) n_to++;
    end
    chk("wd_gnt_cycles", 32'(n_gnt1), 32'd16);
    chk("wd_timeouts",   32'(n_to),   32'd1);
    req_v = 4'b0000;
    step("wd_low");
    req_v = 4'b0010;
    step("wd_regrant");
    chk("wd_regrant_gnt", 32'(gnt), 32'h2);

    // owner 2 drops exactly when the watchdog would fire
    do_reset();
    n_to    = 0;
    dropped = 1'b0;
    req_v   = 4'b0100;
    for (int c = 0; c < 20; c++) begin
      if (!dropped && m_owner == 2 && m_cnt == MAXH) begin
        req_v   = 4'b0000;
        dropped = 1'b1;
      end
      step("edge");
      if (timeout) n_to++;
    end
    chk("edge_timeouts", 32'(n_to), 32'd0);
    req_v = 4'b0100;
    step("edge_regrant");
    chk("edge_regrant_gnt", 32'(gnt), 32'h4);

    // random traffic
    do_reset();
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 7) == 0) req_v[i] = ~req_v[i];
      rand_data();
      step("rnd");
    end

    // asynchronous reset while requester 3 owns the bus
    do_reset();
    din[3] = 32'hDEAD_0003;
    req_v  = 4'b1000;
    step("ar_pre");
    step("ar_pre2");
    chk("ar_owner", 32'(gnt), 32'h8);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("ar_async");
    req_v = 4'b1001;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("ar_after");
    chk("ar_first_winner", 32'(gnt), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
